// File: rtl/noc_2d_packetizer_pkg.sv
// ---------------------------------------------------------------------------
// noc_2d_packetizer_pkg
//
// Shared definitions for the 2D-mesh NoC packetizer:
//   - pkt_state_t     : packetizer FSM states
//   - HDR_LEN_LSB     : bit position of the length field in the header flit
//   - field_width()   : coordinate field width helper, max(1, clog2(n))
//   - hdr_*_lsb()     : header field offsets, all counted down from the flit MSB
// ---------------------------------------------------------------------------
package noc_2d_packetizer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } pkt_state_t;

    // The length field always sits at the bottom of the header flit.
    localparam int HDR_LEN_LSB = 0;

    // A one-row or one-column mesh still needs a 1-bit coordinate field.
    function automatic int field_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int hdr_dest_x_lsb(input int fw, input int xw);
        return fw - xw;
    endfunction

    function automatic int hdr_dest_y_lsb(input int fw, input int xw, input int yw);
        return fw - xw - yw;
    endfunction

    // Source id (src_x above src_y) sits directly below dest_y.
    function automatic int hdr_src_y_lsb(input int fw, input int xw, input int yw);
        return fw - 2 * xw - 2 * yw;
    endfunction

endpackage

// File: rtl/noc_2d_packetizer_flit_reg.sv
// ---------------------------------------------------------------------------
// noc_2d_flit_reg
//
// Single-entry valid/ready output register carrying a flit and its last marker.
// The entry may be reloaded in the same cycle it drains, so a steady stream
// moves at one flit per clock.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   load_valid      new flit offered to the register
//   load_flit       flit to store
//   load_last       last-flit marker to store
//   load_ready      register can take a flit this cycle (empty or draining)
//   flit, last      registered flit and last marker
//   valid           register holds a flit
//   ready           downstream accepts the held flit
// ---------------------------------------------------------------------------
module noc_2d_flit_reg #(
    parameter int FLIT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_valid,
    input  logic [FLIT_WIDTH-1:0] load_flit,
    input  logic                  load_last,
    output logic                  load_ready,
    output logic [FLIT_WIDTH-1:0] flit,
    output logic                  last,
    output logic                  valid,
    input  logic                  ready
);

    assign load_ready = !valid || ready;

    // A load takes priority over a drain so back-to-back flits never bubble.
    // While valid is high and ready is low nothing changes, keeping the
    // flit, last and valid outputs stable for the router.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flit  <= '0;
            last  <= 1'b0;
            valid <= 1'b0;
        end else if (load_valid && load_ready) begin
            flit  <= load_flit;
            last  <= load_last;
            valid <= 1'b1;
        end else if (valid && ready) begin
            last  <= 1'b0;
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/noc_2d_packetizer.sv
// ---------------------------------------------------------------------------
// noc_2d_packetizer
//
// Turns a packet request (destination + payload length) and a stream of
// payload words into NoC flits: one header flit followed by req_len payload
// flits, with noc_last on the final flit of the packet.
//
// Header flit: dest_x in the top XW bits, dest_y in the next YW bits, the
// clamped length in the bottom LW bits, everything else zero.
//
// Optional feature macro: NOC_2D_PACKETIZER_SRC_ID_EN
//   When defined, SRC_X is placed in the XW bits below dest_y and SRC_Y in
//   the YW bits below that. When undefined those bits are zero.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   req_valid / req_ready     packet request handshake
//   req_dest_x, req_dest_y    destination mesh coordinates
//   req_len                   payload flit count (clamped to MAX_LEN)
//   data_valid / data_ready   payload word handshake
//   data                      payload word
//   noc_flit, noc_last        flit and last marker to the router
//   noc_valid / noc_ready     router handshake
// ---------------------------------------------------------------------------
module noc_2d_packetizer
    import noc_2d_packetizer_pkg::*;
#(
    parameter int FLIT_WIDTH = 32,
    parameter int X          = 2,
    parameter int Y          = 2,
    parameter int MAX_LEN    = 8,
    parameter int SRC_X      = 0,
    parameter int SRC_Y      = 0,
    localparam int XW        = field_width(X),
    localparam int YW        = field_width(Y),
    localparam int LW        = $clog2(MAX_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [XW-1:0]         req_dest_x,
    input  logic [YW-1:0]         req_dest_y,
    input  logic [LW-1:0]         req_len,
    input  logic                  data_valid,
    output logic                  data_ready,
    input  logic [FLIT_WIDTH-1:0] data,
    output logic [FLIT_WIDTH-1:0] noc_flit,
    output logic                  noc_last,
    output logic                  noc_valid,
    input  logic                  noc_ready
);

    localparam int DX_LSB = hdr_dest_x_lsb(FLIT_WIDTH, XW);
    localparam int DY_LSB = hdr_dest_y_lsb(FLIT_WIDTH, XW, YW);
    localparam int SY_LSB = hdr_src_y_lsb(FLIT_WIDTH, XW, YW);

`ifdef NOC_2D_PACKETIZER_SRC_ID_EN
    localparam bit SRC_ID_EN = 1'b1;
`else
    localparam bit SRC_ID_EN = 1'b0;
`endif

    localparam logic [XW+YW-1:0] SRC_ID = {XW'(SRC_X), YW'(SRC_Y)};

    pkt_state_t            state;
    logic [XW-1:0]         dest_x_q;
    logic [YW-1:0]         dest_y_q;
    logic [LW-1:0]         len_q;
    logic [LW-1:0]         remaining;
    logic                  running;

    logic [LW-1:0]         len_clamped;
    logic [FLIT_WIDTH-1:0] header;
    logic                  load_valid;
    logic [FLIT_WIDTH-1:0] load_flit;
    logic                  load_last;
    logic                  load_ready;

    assign len_clamped = (req_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : req_len;

    // running is cleared by reset and set on the first clock afterwards, so
    // both ready outputs read 0 for as long as reset is held.
    assign req_ready  = running && (state == IDLE) && load_ready;
    assign data_ready = running && (state == PAYLOAD) && load_ready;

    // Header flit assembled from the latched request fields.
    always_comb begin
        header                      = '0;
        header[DX_LSB +: XW]        = dest_x_q;
        header[DY_LSB +: YW]        = dest_y_q;
        header[SY_LSB +: XW+YW]     = SRC_ID_EN ? SRC_ID : '0;
        header[HDR_LEN_LSB +: LW]   = len_q;
    end

    // Feed the output register: the header while in HEADER, payload words
    // while in PAYLOAD. The final payload word is the one taken when a
    // single flit remains.
    always_comb begin
        load_valid = 1'b0;
        load_flit  = data;
        load_last  = 1'b0;
        if (state == HEADER) begin
            load_valid = 1'b1;
            load_flit  = header;
            load_last  = (len_q == '0);
        end else if (state == PAYLOAD) begin
            load_valid = data_valid;
            load_flit  = data;
            load_last  = (remaining == LW'(1));
        end
    end

    // Packetizer FSM. IDLE latches an accepted request; HEADER waits until
    // the output register can take the header and then moves on to PAYLOAD
    // (or straight back to IDLE for an empty packet); PAYLOAD counts words
    // down and returns to IDLE with the last one. A reset mid-packet simply
    // drops whatever was in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            dest_x_q  <= '0;
            dest_y_q  <= '0;
            len_q     <= '0;
            remaining <= '0;
            running   <= 1'b0;
        end else begin
            running <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        dest_x_q <= req_dest_x;
                        dest_y_q <= req_dest_y;
                        len_q    <= len_clamped;
                        state    <= HEADER;
                    end
                end
                HEADER: begin
                    if (load_ready) begin
                        if (len_q == '0) begin
                            state <= IDLE;
                        end else begin
                            remaining <= len_q;
                            state     <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (data_valid && data_ready) begin
                        remaining <= remaining - LW'(1);
                        if (remaining == LW'(1)) begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    noc_2d_flit_reg #(
        .FLIT_WIDTH (FLIT_WIDTH)
    ) u_flit_reg (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_flit  (load_flit),
        .load_last  (load_last),
        .load_ready (load_ready),
        .flit       (noc_flit),
        .last       (noc_last),
        .valid      (noc_valid),
        .ready      (noc_ready)
    );

endmodule
